// File: rtl/fpu_op_sequencer.sv
// Command-side sequencer for the FPU datapath: issues one op, waits its latency, returns the result.
// Optional FPU_SEQ_ERR_EN adds rsp_err and short-circuits illegal mode 7 to an error response.
module fpu_op_sequencer #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LAT_ADD = 2,
  parameter int unsigned LAT_CMP = 1,
  parameter int unsigned LAT_MUL = 3,
  parameter int unsigned LAT_RCP = 8,
  parameter int unsigned LAT_DIV = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_mode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] fpu_a,
  output logic [WIDTH-1:0] fpu_b,
  output logic [2:0]       fpu_mode,
  input  logic [WIDTH-1:0] fpu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [2:0]       rsp_mode,
  output logic             busy
`ifdef FPU_SEQ_ERR_EN
  ,
  output logic             rsp_err
`endif
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

  state_t     state_q;
  logic [7:0] cnt_q;

  // Counter preload is latency minus one so that LAT=1 samples on the first WAIT edge.
  function automatic logic [7:0] lat_minus_one(input logic [2:0] mode);
    case (mode)
      3'd0, 3'd1: lat_minus_one = 8'(LAT_ADD - 1);
      3'd2, 3'd3: lat_minus_one = 8'(LAT_CMP - 1);
      3'd4:       lat_minus_one = 8'(LAT_MUL - 1);
      3'd5:       lat_minus_one = 8'(LAT_RCP - 1);
      3'd6:       lat_minus_one = 8'(LAT_DIV - 1);
      default:    lat_minus_one = 8'(LAT_ADD - 1);
    endcase
  endfunction

  assign cmd_ready = (state_q == StIdle) && !rst;
  assign busy      = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      fpu_a     <= '0;
      fpu_b     <= '0;
      fpu_mode  <= 3'd0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_mode  <= 3'd0;
`ifdef FPU_SEQ_ERR_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
`ifdef FPU_SEQ_ERR_EN
            if (cmd_mode == 3'd7) begin
              // Illegal op never reaches the datapath.
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              rsp_mode  <= 3'd7;
              rsp_valid <= 1'b1;
              state_q   <= StResp;
            end else begin
              rsp_err  <= 1'b0;
              fpu_a    <= cmd_a;
              fpu_b    <= cmd_b;
              fpu_mode <= cmd_mode;
              rsp_mode <= cmd_mode;
              cnt_q    <= lat_minus_one(cmd_mode);
              state_q  <= StWait;
            end
`else
            fpu_a    <= cmd_a;
            fpu_b    <= cmd_b;
            fpu_mode <= cmd_mode;
            rsp_mode <= cmd_mode;
            cnt_q    <= lat_minus_one(cmd_mode);
            state_q  <= StWait;
`endif
          end
        end
        StWait: begin
          if (cnt_q == 8'd0) begin
            rsp_data  <= fpu_result;
            rsp_valid <= 1'b1;
            state_q   <= StResp;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed self-checking bench for fpu_op_sequencer; the bench plays the datapath by driving
// fpu_result with the expected value only on the edge where the sequencer should sample it.
`timescale 1ns/1ps
module tb_fpu_op_sequencer;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
  localparam logic [31:0] NEG1 = 32'hBF80_0000;
  localparam logic [31:0] TWO  = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_mode;
  logic [31:0] cmd_a, cmd_b;
  logic [31:0] fpu_a, fpu_b;
  logic [2:0]  fpu_mode;
  logic [31:0] fpu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_mode;
  logic        busy;
`ifdef FPU_SEQ_ERR_EN
  logic        rsp_err;
`endif

  int checks = 0;
  int errors = 0;

  fpu_op_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_mode   (fpu_mode),
    .fpu_result (fpu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_mode   (rsp_mode),
    .busy       (busy)
`ifdef FPU_SEQ_ERR_EN
    ,
    .rsp_err    (rsp_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one command for a single edge; caller guarantees cmd_ready is high.
  task automatic accept(input logic [2:0] mode, input logic [31:0] a, input logic [31:0] b);
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_a     = a;
    cmd_b     = b;
    step();
    cmd_valid = 1'b0;
    cmd_mode  = 3'd5;
    cmd_a     = JUNK;
    cmd_b     = JUNK;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 3'd0; cmd_a = '0; cmd_b = '0;
    rsp_ready = 1'b0; fpu_result = JUNK;
    step(); step();
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (fpu_a !== 32'h0 || fpu_b !== 32'h0) begin errors++; $display("FAIL rst_fpu_ab: got %h %h want 0 0", fpu_a, fpu_b); end
    checks++; if (fpu_mode !== 3'd0 || rsp_mode !== 3'd0) begin errors++; $display("FAIL rst_modes: got %0d %0d want 0 0", fpu_mode, rsp_mode); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
    rst = 1'b0; #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_add();
    int low;
    rsp_ready = 1'b1;
    accept(3'd0, 32'h3F80_0000, 32'h4000_0000);
    checks++; if (fpu_a !== 32'h3F80_0000 || fpu_b !== 32'h4000_0000) begin errors++; $display("FAIL add_fpu_ab: got %h %h want 3f800000 40000000", fpu_a, fpu_b); end
    checks++; if (fpu_mode !== 3'd0) begin errors++; $display("FAIL add_fpu_mode: got %0d want 0", fpu_mode); end
    low = (cmd_ready == 1'b0) ? 1 : 0;
    for (int k = 1; k <= 2; k++) begin
      fpu_result = (k == 2) ? 32'h4040_0000 : JUNK;
      step();
      fpu_result = JUNK;
      if (cmd_ready == 1'b0) low++;
      checks++; if (rsp_valid !== (k == 2)) begin errors++; $display("FAIL add_rsp_valid_e%0d: got %b want %b", k, rsp_valid, (k == 2)); end
    end
    checks++; if (rsp_data !== 32'h4040_0000) begin errors++; $display("FAIL add_rsp_data: got %h want 40400000", rsp_data); end
    checks++; if (rsp_mode !== 3'd0) begin errors++; $display("FAIL add_rsp_mode: got %0d want 0", rsp_mode); end
`ifdef FPU_SEQ_ERR_EN
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL add_rsp_err: got %b want 0", rsp_err); end
`endif
    step();
    if (cmd_ready == 1'b0) low++;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_rsp_clear: got %b want 0", rsp_valid); end
    checks++; if (low !== 3) begin errors++; $display("FAIL add_ready_low_cycles: got %0d want 3", low); end
  endtask

  task automatic test_div();
    int busy_cnt, unstable;
    rsp_ready = 1'b1;
    accept(3'd6, 32'h40C0_0000, 32'h4000_0000);
    busy_cnt = busy ? 1 : 0;
    unstable = 0;
    for (int k = 1; k <= 10; k++) begin
      fpu_result = (k == 10) ? 32'h4040_0000 : JUNK;
      step();
      fpu_result = JUNK;
      if (busy) busy_cnt++;
      if (fpu_a !== 32'h40C0_0000) unstable++;
      checks++; if (rsp_valid !== (k == 10)) begin errors++; $display("FAIL div_rsp_valid_e%0d: got %b want %b", k, rsp_valid, (k == 10)); end
    end
    checks++; if (rsp_data !== 32'h4040_0000 || rsp_mode !== 3'd6) begin errors++; $display("FAIL div_rsp: got %h/%0d want 40400000/6", rsp_data, rsp_mode); end
    step();
    if (busy) busy_cnt++;
    checks++; if (busy_cnt !== 11) begin errors++; $display("FAIL div_busy_cycles: got %0d want 11", busy_cnt); end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL div_fpu_a_stable: got %0d changes want 0", unstable); end
    checks++; if (fpu_a !== 32'h40C0_0000 || fpu_mode !== 3'd6) begin errors++; $display("FAIL div_fpu_hold: got %h/%0d want 40c00000/6", fpu_a, fpu_mode); end
  endtask

  task automatic test_backpressure();
    int bad;
    rsp_ready = 1'b0;
    accept(3'd4, 32'h4040_0000, 32'h4000_0000);
    for (int k = 1; k <= 3; k++) begin
      fpu_result = (k == 3) ? 32'h40C0_0000 : JUNK;
      step();
      fpu_result = JUNK;
    end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid: got %b want 1", rsp_valid); end
    bad = 0;
    cmd_valid = 1'b1; cmd_mode = 3'd0; cmd_a = 32'h3F80_0000; cmd_b = 32'h3F80_0000;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rsp_data !== 32'h40C0_0000 || rsp_mode !== 3'd4 || rsp_valid !== 1'b1) bad++;
      if (cmd_ready !== 1'b0 || fpu_a !== 32'h4040_0000 || fpu_mode !== 3'd4) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad); end
    rsp_ready = 1'b1;
    step();
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_handshake: got valid %b ready %b want 0 1", rsp_valid, cmd_ready); end
    checks++; if (fpu_a !== 32'h4040_0000) begin errors++; $display("FAIL bp_no_early_accept: got %h want 40400000", fpu_a); end
    step();
    cmd_valid = 1'b0; cmd_a = JUNK; cmd_b = JUNK;
    checks++; if (fpu_a !== 32'h3F80_0000 || fpu_mode !== 3'd0 || busy !== 1'b1) begin errors++; $display("FAIL bp_second_accept: got %h/%0d busy %b want 3f800000/0 1", fpu_a, fpu_mode, busy); end
    for (int k = 1; k <= 2; k++) begin
      fpu_result = (k == 2) ? 32'h4000_0000 : JUNK;
      step();
      fpu_result = JUNK;
    end
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h4000_0000) begin errors++; $display("FAIL bp_second_rsp: got %b/%h want 1/40000000", rsp_valid, rsp_data); end
    step();
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    rsp_ready = 1'b1;
    accept(3'd4, 32'h40A0_0000, 32'h4000_0000);
    step();
    rst = 1'b1;
    step();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rw_state: got valid %b busy %b want 0 0", rsp_valid, busy); end
    checks++; if (fpu_a !== 32'h0) begin errors++; $display("FAIL rw_fpu_a: got %h want 0", fpu_a); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rw_cmd_ready: got %b want 0", cmd_ready); end
    rst = 1'b0;
    fpu_result = 32'h4120_0000;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rsp_valid) seen++;
    end
    fpu_result = JUNK;
    checks++; if (seen !== 0) begin errors++; $display("FAIL rw_no_response: got %0d responses want 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic        acc;
    int          issued, nr;
    int          t[2];
    logic [31:0] exp_d[2];
    exp_d[0] = 32'h1;
    exp_d[1] = 32'h0;
    t[0] = 0; t[1] = 0;
    issued = 0; nr = 0;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_mode = 3'd3; cmd_a = NEG1; cmd_b = TWO;
    for (int c = 0; c < 20; c++) begin
      acc = cmd_valid && cmd_ready;
      // Compare model: -1.0 < 2.0 yields 1, 2.0 vs -1.0 yields 0.
      if (fpu_a == NEG1 && fpu_b == TWO) fpu_result = 32'h1;
      else if (fpu_a == TWO && fpu_b == NEG1) fpu_result = 32'h0;
      else fpu_result = JUNK;
      step();
      if (acc) begin
        issued++;
        if (issued == 1) begin cmd_a = TWO; cmd_b = NEG1; end
        else cmd_valid = 1'b0;
      end
      if (rsp_valid) begin
        if (nr < 2) begin
          checks++; if (rsp_data !== exp_d[nr] || rsp_mode !== 3'd3) begin errors++; $display("FAIL b2b_rsp%0d: got %h/%0d want %h/3", nr, rsp_data, rsp_mode, exp_d[nr]); end
          t[nr] = c;
        end else begin
          errors++; $display("FAIL b2b_extra_rsp: got %0d responses want 2", nr + 1);
        end
        nr++;
      end
    end
    cmd_valid = 1'b0; fpu_result = JUNK;
    checks++; if (nr !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", nr); end
    checks++; if (t[1] - t[0] !== 3) begin errors++; $display("FAIL b2b_spacing: got %0d want 3", t[1] - t[0]); end
  endtask

  task automatic test_mode7();
    rsp_ready = 1'b1;
`ifdef FPU_SEQ_ERR_EN
    accept(3'd7, 32'h1111_1111, 32'h2222_2222);
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("FAIL m7_err: got valid %b err %b want 1 1", rsp_valid, rsp_err); end
    checks++; if (rsp_data !== 32'h0 || rsp_mode !== 3'd7) begin errors++; $display("FAIL m7_rsp: got %h/%0d want 0/7", rsp_data, rsp_mode); end
    checks++; if (fpu_a !== TWO || fpu_b !== NEG1 || fpu_mode !== 3'd3) begin errors++; $display("FAIL m7_fpu_hold: got %h %h %0d want 40000000 bf800000 3", fpu_a, fpu_b, fpu_mode); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL m7_clear: got %b want 0", rsp_valid); end
`else
    accept(3'd7, 32'h1111_1111, 32'h2222_2222);
    checks++; if (fpu_a !== 32'h1111_1111 || fpu_mode !== 3'd7) begin errors++; $display("FAIL m7_issue: got %h/%0d want 11111111/7", fpu_a, fpu_mode); end
    for (int k = 1; k <= 2; k++) begin
      fpu_result = (k == 2) ? 32'h7FC0_0000 : JUNK;
      step();
      fpu_result = JUNK;
      checks++; if (rsp_valid !== (k == 2)) begin errors++; $display("FAIL m7_rsp_valid_e%0d: got %b want %b", k, rsp_valid, (k == 2)); end
    end
    checks++; if (rsp_data !== 32'h7FC0_0000 || rsp_mode !== 3'd7) begin errors++; $display("FAIL m7_rsp: got %h/%0d want 7fc00000/7", rsp_data, rsp_mode); end
    step();
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_div();
    test_backpressure();
    test_reset_mid_wait();
    test_back_to_back();
    test_mode7();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_op_sequencer.md
# fpu_op_sequencer

Command-side front end for the FPU datapath: it accepts one floating-point operation at a time over a valid/ready command channel and drives the datapath's `a`, `b` and `mode` inputs. It holds those inputs stable for the operation's configured pipeline latency, then samples the datapath `result` and returns it on a valid/ready response channel. It sits between a host/bus adapter and the FPU datapath, which has no handshake of its own.

## Interface
- `WIDTH`, 32, operand/result width
- `LAT_ADD`, 2, cycles from operand change to valid result, modes 0–1 (min 1, max 255)
- `LAT_CMP`, 1, latency, modes 2–3
- `LAT_MUL`, 3, latency, mode 4
- `LAT_RCP`, 8, latency, mode 5
- `LAT_DIV`, 10, latency, mode 6
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  sequencer can accept a command
- `cmd_mode`  in  3  operation: 0 add, 1 sub, 2 mag-compare, 3 compare, 4 mul, 5 recip, 6 div, 7 illegal
- `cmd_a`, `cmd_b`  in  WIDTH  operands
- `fpu_a`, `fpu_b`  out  WIDTH  registered operands to the datapath
- `fpu_mode`  out  3  registered mode to the datapath
- `fpu_result`  in  WIDTH  datapath result
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer takes response
- `rsp_data`  out  WIDTH  captured result
- `rsp_mode`  out  3  mode of the completed op
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, WAIT, RESP.
- `cmd_ready` = (state==IDLE) && !rst, combinational.
- IDLE: on `cmd_valid && cmd_ready`, register `cmd_a/b/mode` into `fpu_a/b/mode` and `rsp_mode`, load 8-bit counter with LAT(mode)−1, go to WAIT.
- WAIT: if counter==0, register `fpu_result` into `rsp_data`, set `rsp_valid`, go to RESP; else decrement the counter.
- RESP: hold `rsp_data`, `rsp_mode`, `rsp_valid` stable until `rsp_ready`. On the handshake edge, clear `rsp_valid` and go to IDLE.
- No new command is accepted in WAIT or RESP; `cmd_*` are ignored there.
- `fpu_a/b/mode` change only on accept. After completion they keep the last issued values, so the datapath is not toggled.
- Mode 7 without the macro is treated as a normal op with latency LAT_ADD; the result is captured as-is.
- Reset:
  - state IDLE, counter 0.
  - `fpu_a`, `fpu_b`, `rsp_data` = 0; `fpu_mode`, `rsp_mode` = 0.
  - `rsp_valid`, `busy` and `cmd_ready` (while `rst` is high) = 0.
- Reset in WAIT or RESP aborts the op; no response is emitted for it.

## Timing
- Accept on edge E0. `fpu_*` are valid after E0. `fpu_result` is sampled on edge E0+LAT. `rsp_valid` is high after E0+LAT.
- When `rsp_ready` is already high, the response handshake occurs on edge E0+LAT+1. IDLE is reached after that edge, and the next accept can occur at E0+LAT+2 at the earliest.
- Throughput: one op per LAT+2 cycles with no backpressure.
- `rsp_*` are registered; `cmd_ready` and `busy` are state-decoded.

## Configuration
- `FPU_SEQ_ERR_EN` defined:
  - Adds output `rsp_err` (1 bit, reset 0).
  - An accepted mode 7 does not update `fpu_*` and goes directly IDLE→RESP on the next edge, with `rsp_err=1`, `rsp_data=0` and `rsp_mode=7`.
  - `rsp_err` is 0 for all other modes.
- Undefined: no `rsp_err` port; mode 7 follows the normal path described in Operation.

## Test plan
- Add, LAT_ADD=2, `rsp_ready`=1: `a`=0x3F800000, `b`=0x40000000, mode 0 -> `rsp_data`=0x40400000 with `rsp_valid` high after edge E0+2; `cmd_ready` low for exactly 3 cycles.
- Div, LAT_DIV=10: 0x40C00000 / 0x40000000 -> 0x40400000 after E0+10; `busy` high for 11 cycles; `fpu_a` stable throughout.
- Backpressure: `rsp_ready` held low 6 cycles after the response -> `rsp_data`/`rsp_mode` unchanged, `cmd_ready`=0, and a second `cmd_valid` is not accepted; accept occurs 1 cycle after the handshake.
- Reset mid-WAIT (mul, 1 cycle after accept) -> next cycle `rsp_valid`=0, `fpu_a`=0, `busy`=0; no response ever appears for that op.
- Back-to-back compare ops (mode 3, −1.0 vs 2.0, then 2.0 vs −1.0) -> two responses in order with the correct `rsp_mode`, spaced LAT_CMP+2 cycles apart.
- With `FPU_SEQ_ERR_EN`, mode 7 -> `rsp_err`=1, `rsp_data`=0 one cycle after accept, `fpu_*` unchanged. Without the macro, `rsp_valid` asserts after E0+LAT_ADD.
